// File: rtl/host_sq_router.sv
// Round-robin submission-queue arbiter that routes each descriptor atomically to local/remote
// read/write output FIFOs. Remote outputs exist only when HOST_SQ_ROUTER_REMOTE_EN is defined.
module host_sq_router #(
   parameter int unsigned N_SRC    = 2,
   parameter int unsigned REQ_BITS = 128,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned SRC_BITS = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [N_SRC-1:0]             s_sq_valid,
   output logic [N_SRC-1:0]             s_sq_ready,
   input  logic [N_SRC*REQ_BITS-1:0]    s_sq_req1,
   input  logic [N_SRC*REQ_BITS-1:0]    s_sq_req2,
   input  logic [N_SRC-1:0]             s_sq_actv1,
   input  logic [N_SRC-1:0]             s_sq_actv2,
   input  logic [N_SRC-1:0]             s_sq_rmt1,
   input  logic [N_SRC-1:0]             s_sq_rmt2,
   output logic                         m_lrd_valid,
   input  logic                         m_lrd_ready,
   output logic [REQ_BITS-1:0]          m_lrd_data,
   output logic [SRC_BITS-1:0]          m_lrd_src,
   output logic                         m_lwr_valid,
   input  logic                         m_lwr_ready,
   output logic [REQ_BITS-1:0]          m_lwr_data,
   output logic [SRC_BITS-1:0]          m_lwr_src,
   output logic                         m_rrd_valid,
   input  logic                         m_rrd_ready,
   output logic [2*REQ_BITS-1:0]        m_rrd_data,
   output logic [1:0]                   m_rrd_actv,
   output logic [SRC_BITS-1:0]          m_rrd_src,
   output logic                         m_rwr_valid,
   input  logic                         m_rwr_ready,
   output logic [2*REQ_BITS-1:0]        m_rwr_data,
   output logic [1:0]                   m_rwr_actv,
   output logic [SRC_BITS-1:0]          m_rwr_src,
   output logic [31:0]                  drop_cnt
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned IW = SRC_BITS + 1;
   localparam int unsigned NW = REQ_BITS + SRC_BITS;
   localparam int unsigned FW = 2 * REQ_BITS + 2 + SRC_BITS;
`ifdef HOST_SQ_ROUTER_REMOTE_EN
   localparam int unsigned N_OUT = 4;
`else
   localparam int unsigned N_OUT = 2;
`endif

   // Output index order: 0 lrd, 1 lwr, 2 rrd, 3 rwr
   logic [SRC_BITS-1:0]    rr_q, rr_d;
   logic [31:0]            drop_cnt_q, drop_cnt_d;
   logic                   cand_found;
   logic [SRC_BITS-1:0]    cand;
   logic [IW-1:0]          idx;
   logic                   a1, a2, r1, r2;
   logic [REQ_BITS-1:0]    c_req1, c_req2;
   logic [3:0]             need, space, push, out_valid, out_ready;
   logic                   accept;
   logic [3:0][CW-1:0]     cnt;
   logic [NW-1:0]          lrd_wdata, lwr_wdata;
   logic [FW-1:0]          rmt_wdata;
   logic [1:0][NW-1:0]     head_loc;
   logic [1:0][FW-1:0]     head_rmt;

   always_comb begin
      cand_found = 1'b0;
      cand       = '0;
      idx        = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         idx = {1'b0, rr_q} + IW'(k);
         if (idx >= IW'(N_SRC)) idx = idx - IW'(N_SRC);
         if (!cand_found && s_sq_valid[idx[SRC_BITS-1:0]]) begin
            cand_found = 1'b1;
            cand       = idx[SRC_BITS-1:0];
         end
      end
   end

   assign a1     = s_sq_actv1[cand];
   assign a2     = s_sq_actv2[cand];
   assign c_req1 = s_sq_req1[REQ_BITS*cand +: REQ_BITS];
   assign c_req2 = s_sq_req2[REQ_BITS*cand +: REQ_BITS];

`ifdef HOST_SQ_ROUTER_REMOTE_EN
   assign r1 = s_sq_rmt1[cand];
   assign r2 = s_sq_rmt2[cand];
`else
   logic unused_rmt;
   assign r1 = 1'b0;
   assign r2 = 1'b0;
   assign unused_rmt = ^{s_sq_rmt1, s_sq_rmt2, out_ready[3:2], rmt_wdata};
`endif

   // Remote write also needs a local read slot to fetch the outgoing payload
   assign need[0] = (a1 & a2) | (a1 & ~r1) | (~a1 & a2 & r2);
   assign need[1] = (a1 & a2) | (~a1 & a2 & ~r2);
   assign need[2] = a1 & ~a2 & r1;
   assign need[3] = ~a1 & a2 & r2;

   always_comb begin
      for (int unsigned g = 0; g < 4; g++) begin
         space[g] = ~need[g] | (cnt[g] < CW'(DEPTH));
      end
   end

   assign accept = cand_found & (&space);
   assign push   = need & {4{accept}};

   always_comb begin
      s_sq_ready = '0;
      if (accept) s_sq_ready[cand] = 1'b1;
   end

   assign lrd_wdata = {cand, a1 ? c_req1 : c_req2};
   assign lwr_wdata = {cand, c_req2};
   assign rmt_wdata = {cand, a2, a1, c_req2, c_req1};

   always_comb begin
      rr_d       = rr_q;
      drop_cnt_d = drop_cnt_q;
      if (accept) begin
         rr_d = (cand == SRC_BITS'(N_SRC - 1)) ? '0 : cand + 1'b1;
         if (!a1 && !a2) drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rr_q       <= '0;
         drop_cnt_q <= '0;
      end else begin
         rr_q       <= rr_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign out_ready = {m_rwr_ready, m_rrd_ready, m_lwr_ready, m_lrd_ready};

   for (genvar g = 0; g < 4; g++) begin : g_out
      if (g < N_OUT) begin : g_fifo
         localparam int unsigned W = (g < 2) ? NW : FW;
         logic [W-1:0]  mem_q [DEPTH];
         logic [W-1:0]  wdata;
         logic [PW-1:0] wr_ptr_q, rd_ptr_q;
         logic [CW-1:0] cnt_q;
         logic          pop;

         if (g == 0) begin : g_wd_lrd
            assign wdata = lrd_wdata;
         end else if (g == 1) begin : g_wd_lwr
            assign wdata = lwr_wdata;
         end else begin : g_wd_rmt
            assign wdata = rmt_wdata;
         end

         assign pop = (cnt_q != '0) & out_ready[g];

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
            end else begin
               if (push[g]) wr_ptr_q <= wr_ptr_q + 1'b1;
               if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
               cnt_q <= cnt_q + CW'(push[g]) - CW'(pop);
            end
         end

         always_ff @(posedge aclk) begin
            if (push[g]) mem_q[wr_ptr_q] <= wdata;
         end

         assign cnt[g]       = cnt_q;
         assign out_valid[g] = (cnt_q != '0);
         if (g < 2) begin : g_head_loc
            assign head_loc[g] = mem_q[rd_ptr_q];
         end else begin : g_head_rmt
            assign head_rmt[g-2] = mem_q[rd_ptr_q];
         end
      end else begin : g_none
         assign cnt[g]        = '0;
         assign out_valid[g]  = 1'b0;
         assign head_rmt[g-2] = '0;
      end
   end

   assign m_lrd_valid = out_valid[0];
   assign m_lrd_data  = head_loc[0][REQ_BITS-1:0];
   assign m_lrd_src   = head_loc[0][REQ_BITS +: SRC_BITS];
   assign m_lwr_valid = out_valid[1];
   assign m_lwr_data  = head_loc[1][REQ_BITS-1:0];
   assign m_lwr_src   = head_loc[1][REQ_BITS +: SRC_BITS];
   assign m_rrd_valid = out_valid[2];
   assign m_rrd_data  = head_rmt[0][2*REQ_BITS-1:0];
   assign m_rrd_actv  = head_rmt[0][2*REQ_BITS +: 2];
   assign m_rrd_src   = head_rmt[0][2*REQ_BITS+2 +: SRC_BITS];
   assign m_rwr_valid = out_valid[3];
   assign m_rwr_data  = head_rmt[1][2*REQ_BITS-1:0];
   assign m_rwr_actv  = head_rmt[1][2*REQ_BITS +: 2];
   assign m_rwr_src   = head_rmt[1][2*REQ_BITS+2 +: SRC_BITS];
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_host_sq_router.sv
// Directed bench for host_sq_router: arbitration order, routing, back-pressure, drop counter,
// mid-operation reset. Remote-path steps run only when HOST_SQ_ROUTER_REMOTE_EN is defined.
module tb_host_sq_router;

   localparam int unsigned NS = 2;
   localparam int unsigned RB = 16;
   localparam int unsigned SB = 1;

   logic              clk = 1'b0;
   logic              aresetn;
   logic [NS-1:0]     s_sq_valid, s_sq_ready;
   logic [NS*RB-1:0]  s_sq_req1, s_sq_req2;
   logic [NS-1:0]     s_sq_actv1, s_sq_actv2, s_sq_rmt1, s_sq_rmt2;
   logic              m_lrd_valid, m_lrd_ready, m_lwr_valid, m_lwr_ready;
   logic [RB-1:0]     m_lrd_data, m_lwr_data;
   logic [SB-1:0]     m_lrd_src, m_lwr_src, m_rrd_src, m_rwr_src;
   logic              m_rrd_valid, m_rrd_ready, m_rwr_valid, m_rwr_ready;
   logic [2*RB-1:0]   m_rrd_data, m_rwr_data;
   logic [1:0]        m_rrd_actv, m_rwr_actv;
   logic [31:0]       drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   host_sq_router #(.N_SRC(NS), .REQ_BITS(RB), .DEPTH(4)) dut (
      .aclk(clk), .aresetn(aresetn),
      .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready),
      .s_sq_req1(s_sq_req1), .s_sq_req2(s_sq_req2),
      .s_sq_actv1(s_sq_actv1), .s_sq_actv2(s_sq_actv2),
      .s_sq_rmt1(s_sq_rmt1), .s_sq_rmt2(s_sq_rmt2),
      .m_lrd_valid(m_lrd_valid), .m_lrd_ready(m_lrd_ready),
      .m_lrd_data(m_lrd_data), .m_lrd_src(m_lrd_src),
      .m_lwr_valid(m_lwr_valid), .m_lwr_ready(m_lwr_ready),
      .m_lwr_data(m_lwr_data), .m_lwr_src(m_lwr_src),
      .m_rrd_valid(m_rrd_valid), .m_rrd_ready(m_rrd_ready),
      .m_rrd_data(m_rrd_data), .m_rrd_actv(m_rrd_actv), .m_rrd_src(m_rrd_src),
      .m_rwr_valid(m_rwr_valid), .m_rwr_ready(m_rwr_ready),
      .m_rwr_data(m_rwr_data), .m_rwr_actv(m_rwr_actv), .m_rwr_src(m_rwr_src),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic a1, input logic a2,
                          input logic r1, input logic r2,
                          input logic [RB-1:0] q1, input logic [RB-1:0] q2);
      s_sq_valid[i]       = v;
      s_sq_actv1[i]       = a1;
      s_sq_actv2[i]       = a2;
      s_sq_rmt1[i]        = r1;
      s_sq_rmt2[i]        = r2;
      s_sq_req1[i*RB +: RB] = q1;
      s_sq_req2[i*RB +: RB] = q2;
   endtask

   task automatic set_ready(input logic [3:0] r);
      {m_rwr_ready, m_rrd_ready, m_lwr_ready, m_lrd_ready} = r;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      #1;
      @(negedge clk);
      aresetn = 1'b1;
   endtask

   initial begin
      aresetn    = 1'b0;
      s_sq_valid = '0; s_sq_actv1 = '0; s_sq_actv2 = '0;
      s_sq_rmt1  = '0; s_sq_rmt2  = '0; s_sq_req1  = '0; s_sq_req2 = '0;
      set_ready(4'b0000);
      #2;
      chk("reset_sq_ready", s_sq_ready, 2'b00);
      chk("reset_lrd_valid", m_lrd_valid, 1'b0);
      chk("reset_lwr_valid", m_lwr_valid, 1'b0);
      chk("reset_rrd_valid", m_rrd_valid, 1'b0);
      chk("reset_rwr_valid", m_rwr_valid, 1'b0);
      chk("reset_drop_cnt", drop_cnt, 32'd0);
      @(negedge clk);
      aresetn = 1'b1;

      // Single local read, one-cycle latency
      set_src(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00A5, 16'h0000);
      #1;
      chk("t1_ready", s_sq_ready, 2'b01);
      tick();
      chk("t1_lrd_valid", m_lrd_valid, 1'b1);
      chk("t1_lrd_data", m_lrd_data, 16'h00A5);
      chk("t1_lrd_src", m_lrd_src, 1'b0);
      chk("t1_lwr_valid", m_lwr_valid, 1'b0);
      chk("t1_rrd_valid", m_rrd_valid, 1'b0);
      s_sq_valid = '0;
      m_lrd_ready = 1'b1;
      tick();
      chk("t1_lrd_drained", m_lrd_valid, 1'b0);

      // Round-robin between two continuously valid sources
      do_reset();
      set_ready(4'b1111);
      set_src(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      set_src(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_ready_%0d", k), s_sq_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         chk($sformatf("t2_src_%0d", k), m_lrd_src, (k % 2 == 0) ? 1'b0 : 1'b1);
         chk($sformatf("t2_data_%0d", k), m_lrd_data, (k % 2 == 0) ? 16'h0010 : 16'h0020);
      end
      s_sq_valid = '0;
      tick();
      chk("t2_drained", m_lrd_valid, 1'b0);
      set_src(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_src(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Drop counter and its wrap
      set_src(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0002);
      #1;
      chk("t4_ready", s_sq_ready, 2'b01);
      tick();
      chk("t4_drop_1", drop_cnt, 32'd1);
      chk("t4_lrd_valid", m_lrd_valid, 1'b0);
      chk("t4_lwr_valid", m_lwr_valid, 1'b0);
      s_sq_valid = '0;
      force dut.drop_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.drop_cnt_q;
      #1;
      chk("t4_drop_preload", drop_cnt, 32'hFFFF_FFFF);
      s_sq_valid[0] = 1'b1;
      tick();
      chk("t4_drop_wrap", drop_cnt, 32'd0);
      s_sq_valid = '0;

      // Fill lwr, full blocks, drain one then refill, then mid-operation reset
      set_ready(4'b0000);
      for (int k = 0; k < 4; k++) begin
         set_src(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0030 + 16'(k));
         #1;
         chk($sformatf("t5_fill_ready_%0d", k), s_sq_ready, 2'b01);
         tick();
      end
      chk("t5_full_ready", s_sq_ready, 2'b00);
      chk("t5_full_valid", m_lwr_valid, 1'b1);
      chk("t5_head_data", m_lwr_data, 16'h0030);
      chk("t5_head_src", m_lwr_src, 1'b0);
      set_src(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0034);
      m_lwr_ready = 1'b1;
      #1;
      chk("t5_no_ready_path", s_sq_ready, 2'b00);
      tick();
      m_lwr_ready = 1'b0;
      #1;
      chk("t5_after_pop_ready", s_sq_ready, 2'b01);
      chk("t5_after_pop_head", m_lwr_data, 16'h0031);
      tick();
      chk("t5_refull_ready", s_sq_ready, 2'b00);
      chk("t5_hold_head", m_lwr_data, 16'h0031);
      s_sq_valid = '0;
      aresetn = 1'b0;
      #1;
      chk("t5_rst_lwr_valid", m_lwr_valid, 1'b0);
      chk("t5_rst_lrd_valid", m_lrd_valid, 1'b0);
      @(negedge clk);
      aresetn = 1'b1;
      set_src(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_src(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0077);
      m_lwr_ready = 1'b1;
      #1;
      chk("t5_post_ready", s_sq_ready, 2'b10);
      tick();
      chk("t5_post_valid", m_lwr_valid, 1'b1);
      chk("t5_post_data", m_lwr_data, 16'h0077);
      chk("t5_post_src", m_lwr_src, 1'b1);
      s_sq_valid = '0;
      tick();
      chk("t5_post_drained", m_lwr_valid, 1'b0);
      set_src(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_ready(4'b0000);

`ifdef HOST_SQ_ROUTER_REMOTE_EN
      // Remote write waits for a local-read slot, then both push together
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_src(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040 + 16'(k), 16'h0000);
         tick();
      end
      set_src(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00C1, 16'h00B0);
      #1;
      chk("t3_blocked_ready", s_sq_ready, 2'b00);
      tick();
      chk("t3_blocked_rwr", m_rwr_valid, 1'b0);
      m_lrd_ready = 1'b1;
      #1;
      chk("t3_pop_cycle_ready", s_sq_ready, 2'b00);
      tick();
      m_lrd_ready = 1'b0;
      #1;
      chk("t3_slot_ready", s_sq_ready, 2'b01);
      chk("t3_slot_rwr", m_rwr_valid, 1'b0);
      tick();
      chk("t3_rwr_valid", m_rwr_valid, 1'b1);
      chk("t3_rwr_data", m_rwr_data, 32'h00B0_00C1);
      chk("t3_rwr_actv", m_rwr_actv, 2'b10);
      chk("t3_rwr_src", m_rwr_src, 1'b0);
      chk("t3_lrd_full", s_sq_ready, 2'b00);
      set_src(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00D1, 16'h00E2);
      #1;
      chk("t3_rrd_ready", s_sq_ready, 2'b01);
      tick();
      chk("t3_rrd_valid", m_rrd_valid, 1'b1);
      chk("t3_rrd_data", m_rrd_data, 32'h00E2_00D1);
      chk("t3_rrd_actv", m_rrd_actv, 2'b01);
      s_sq_valid = '0;
      set_ready(4'b1111);
      for (int k = 0; k < 6; k++) tick();
      chk("t3_drained", {m_rwr_valid, m_rrd_valid, m_lwr_valid, m_lrd_valid}, 4'b0000);
`else
      // Remote flags ignored: actv1-only goes to lrd, actv2-only goes to lwr
      set_src(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h005A, 16'h0000);
      #1;
      chk("t6_ready_rd", s_sq_ready, 2'b01);
      tick();
      chk("t6_lrd_valid", m_lrd_valid, 1'b1);
      chk("t6_lrd_data", m_lrd_data, 16'h005A);
      chk("t6_rrd_valid", m_rrd_valid, 1'b0);
      set_src(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h006B);
      #1;
      chk("t6_ready_wr", s_sq_ready, 2'b01);
      tick();
      chk("t6_lwr_valid", m_lwr_valid, 1'b1);
      chk("t6_lwr_data", m_lwr_data, 16'h006B);
      chk("t6_rwr_valid", m_rwr_valid, 1'b0);
      s_sq_valid = '0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
